// File: rtl/score_keeper_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : score_keeper_if                                          |
// | Description : Bundles the playfield/button inputs and the score,       |
// |               restart and HEX outputs of the match scorekeeper.        |
// |               master = game/bench side, slave = score_keeper.          |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface score_keeper_if #(
  parameter int CNT_W = 4
);
  logic             led_left;
  logic             led_right;
  logic             btn_l;
  logic             btn_r;
  logic             new_match;
  logic             restart;
  logic [CNT_W-1:0] score_l;
  logic [CNT_W-1:0] score_r;
  logic [6:0]       hex_l;
  logic [6:0]       hex_r;
  logic             match_over;
  logic [1:0]       winner;

  modport master (
    output led_left, led_right, btn_l, btn_r, new_match,
    input  restart, score_l, score_r, hex_l, hex_r, match_over, winner
  );

  modport slave (
    input  led_left, led_right, btn_l, btn_r, new_match,
    output restart, score_l, score_r, hex_l, hex_r, match_over, winner
  );
endinterface
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : score_keeper                                             |
// | Description : Tug-of-war match scorekeeper. Detects a point at either  |
// |               goal, keeps per-side scores up to WIN_SCORE, issues a    |
// |               timed field-restart pulse and latches the winner until   |
// |               new_match. Optional winner-digit blink is enabled by     |
// |               defining SCORE_KEEPER_BLINK_EN.                          |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module score_keeper #(
  parameter int WIN_SCORE      = 7,
  parameter int CNT_W          = 4,
  parameter int RESTART_CYCLES = 2,
  parameter int BLINK_CYCLES   = 4
) (
  input wire            clk,
  input wire            reset,
  score_keeper_if.slave bus
);

  typedef enum logic [1:0] {
    ST_PLAY    = 2'd0,
    ST_RESTART = 2'd1,
    ST_OVER    = 2'd2
  } state_t;

  // Counter holds "remaining cycles after this one", so it loads one less.
  localparam logic [7:0]       RESTART_LOAD = 8'(RESTART_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_VAL      = CNT_W'(WIN_SCORE);

  // Elaboration-time parameter sanity checks
  if (WIN_SCORE < 1 || WIN_SCORE > 15 || (2 ** CNT_W) <= WIN_SCORE) begin : g_bad_win
    $error("score_keeper: WIN_SCORE must be 1..15 and fit in CNT_W bits");
  end
  if (RESTART_CYCLES < 1 || RESTART_CYCLES > 255) begin : g_bad_restart
    $error("score_keeper: RESTART_CYCLES must be 1..255");
  end
  if (BLINK_CYCLES < 1) begin : g_bad_blink
    $error("score_keeper: BLINK_CYCLES must be at least 1");
  end

  state_t           state_q,      state_d;
  logic [CNT_W-1:0] score_l_q,    score_l_d;
  logic [CNT_W-1:0] score_r_q,    score_r_d;
  logic             restart_q,    restart_d;
  logic             match_over_q, match_over_d;
  logic [1:0]       winner_q,     winner_d;
  logic [7:0]       rcnt_q,       rcnt_d;

  logic             w_pt_l;
  logic             w_pt_r;
  logic [CNT_W-1:0] w_inc_l;
  logic [CNT_W-1:0] w_inc_r;
  logic             w_blank_l;
  logic             w_blank_r;

  // Pressing both buttons at once never scores.
  assign w_pt_l  = bus.led_left  & bus.btn_l & ~bus.btn_r;
  assign w_pt_r  = bus.led_right & bus.btn_r & ~bus.btn_l;
  assign w_inc_l = score_l_q + CNT_W'(1);
  assign w_inc_r = score_r_q + CNT_W'(1);

  // Next-state logic: scoring in PLAY, restart pulse timing, match latch.
  always_comb begin
    state_d      = state_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    restart_d    = restart_q;
    match_over_d = match_over_q;
    winner_d     = winner_q;
    rcnt_d       = rcnt_q;
    case (state_q)
      ST_PLAY: begin
        if (w_pt_l) begin
          score_l_d = w_inc_l;
          restart_d = 1'b1;
          rcnt_d    = RESTART_LOAD;
          if (w_inc_l == WIN_VAL) begin
            state_d      = ST_OVER;
            match_over_d = 1'b1;
            winner_d     = 2'b01;
          end else begin
            state_d = ST_RESTART;
          end
        end else if (w_pt_r) begin
          score_r_d = w_inc_r;
          restart_d = 1'b1;
          rcnt_d    = RESTART_LOAD;
          if (w_inc_r == WIN_VAL) begin
            state_d      = ST_OVER;
            match_over_d = 1'b1;
            winner_d     = 2'b10;
          end else begin
            state_d = ST_RESTART;
          end
        end
      end
      ST_RESTART: begin
        if (rcnt_q == 8'd0) begin
          restart_d = 1'b0;
          state_d   = ST_PLAY;
        end else begin
          rcnt_d = rcnt_q - 8'd1;
        end
      end
      ST_OVER: begin
        if (bus.new_match) begin
          state_d      = ST_PLAY;
          score_l_d    = '0;
          score_r_d    = '0;
          match_over_d = 1'b0;
          winner_d     = 2'b00;
          restart_d    = 1'b0;
          rcnt_d       = 8'd0;
        end else if (restart_q) begin
          if (rcnt_q == 8'd0) begin
            restart_d = 1'b0;
          end else begin
            rcnt_d = rcnt_q - 8'd1;
          end
        end
      end
      default: state_d = ST_PLAY;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_PLAY;
      score_l_q    <= '0;
      score_r_q    <= '0;
      restart_q    <= 1'b0;
      match_over_q <= 1'b0;
      winner_q     <= 2'b00;
      rcnt_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      restart_q    <= restart_d;
      match_over_q <= match_over_d;
      winner_q     <= winner_d;
      rcnt_q       <= rcnt_d;
    end
  end

`ifdef SCORE_KEEPER_BLINK_EN
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_off_q, blink_off_d;

  // Blink phase runs only while a result is latched; starts in the "digit shown" phase.
  always_comb begin
    blink_cnt_d = '0;
    blink_off_d = 1'b0;
    if (state_q == ST_OVER && !bus.new_match) begin
      if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        blink_off_d = blink_off_q;
      end
    end
  end

  // Blink phase registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  assign w_blank_l = blink_off_q & (winner_q == 2'b01);
  assign w_blank_r = blink_off_q & (winner_q == 2'b10);
`else
  assign w_blank_l = 1'b0;
  assign w_blank_r = 1'b0;
`endif

  // Active-low 7-segment decode, segment order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  assign bus.restart    = restart_q;
  assign bus.score_l    = score_l_q;
  assign bus.score_r    = score_r_q;
  assign bus.match_over = match_over_q;
  assign bus.winner     = winner_q;
  assign bus.hex_l      = w_blank_l ? 7'b1111111 : seg7(4'(score_l_q));
  assign bus.hex_r      = w_blank_r ? 7'b1111111 : seg7(4'(score_r_q));

endmodule
`default_nettype wire
